// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: CPU bus responder, byte FIFO, status register
// and a level interrupt raised while idle with nothing left to send.
module uart_tx_port #(
    parameter int CLK_DIVIDER = 104,
    parameter int FIFO_BITS   = 3
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        sel,
    input  logic        mem_address,
    input  logic        mem_valid,
    input  logic        mem_nwr,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_data_out,
    output logic        mem_ready,
    output logic        tx,
    output logic        interrupt,
    input  logic        interrupt_clear
);
    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int CNT_W = FIFO_BITS + 1;
    localparam int DIV_W = (CLK_DIVIDER > 2) ? $clog2(CLK_DIVIDER) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIVIDER - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    tx_state_t            state, state_nxt;
    logic [DIV_W-1:0]     div_cnt, div_nxt;
    logic [2:0]           bit_cnt, bit_nxt;
    logic [7:0]           shift, shift_nxt;
    logic                 tx_nxt;

    logic [7:0]           fifo_mem [DEPTH];
    logic [FIFO_BITS-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 full, empty, busy, overflow, irq_en;
    logic                 req, wr_data, wr_status, rd_any, push, pop;

    function automatic logic [31:0] status_word(input logic [CNT_W-1:0] cnt,
                                                input logic ovf, input logic bsy,
                                                input logic emp, input logic ful);
        logic [7:0] cnt8;
        cnt8 = 8'(cnt);
        return {16'b0, cnt8, 4'b0, ovf, bsy, emp, ful};
    endfunction

    // A request is taken once, on the edge before mem_ready rises.
    assign req       = mem_valid & sel & ~mem_ready;
    assign wr_data   = req & ~mem_nwr & ~mem_address;
    assign wr_status = req & ~mem_nwr & mem_address;
    assign rd_any    = req & mem_nwr;
    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign busy      = (state != S_IDLE);
    assign push      = wr_data & ~full;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mem_ready    <= 1'b0;
            mem_data_out <= '0;
            overflow     <= 1'b0;
            irq_en       <= 1'b0;
            interrupt    <= 1'b0;
        end else begin
            mem_ready <= mem_valid & sel;
            if (rd_any)
                mem_data_out <= status_word(count, overflow, busy, empty, full);
            if (rd_any && mem_address)
                overflow <= 1'b0;
            else if (wr_data && full)
                overflow <= 1'b1;
            if (interrupt_clear)
                irq_en <= 1'b0;
            else if (wr_status)
                irq_en <= mem_data_in[0];
            interrupt <= irq_en & empty & ~busy;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= mem_data_in[7:0];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + FIFO_BITS'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_BITS'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            shift   <= shift_nxt;
            tx      <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        tx_nxt    = tx;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                tx_nxt = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_mem[rd_ptr];
                    tx_nxt    = 1'b0;
                    div_nxt   = '0;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (div_cnt == DIV_LAST) begin
                    div_nxt   = '0;
                    bit_nxt   = '0;
                    tx_nxt    = shift[0];
                    state_nxt = S_DATA;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (div_cnt == DIV_LAST) begin
                    div_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = S_STOP;
                    end else begin
                        bit_nxt   = bit_cnt + 3'd1;
                        shift_nxt = shift >> 1;
                        tx_nxt    = shift[1];
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            default: begin
                // Stop bit: chain straight into the next start bit when data is waiting.
                if (div_cnt == DIV_LAST) begin
                    div_nxt = '0;
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_nxt = fifo_mem[rd_ptr];
                        tx_nxt    = 1'b0;
                        state_nxt = S_START;
                    end else begin
                        tx_nxt    = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port with CLK_DIVIDER=4, FIFO_BITS=3.
module tb_uart_tx_port;
    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        sel = 1'b0;
    logic        mem_address = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_nwr = 1'b1;
    logic [31:0] mem_data_in = '0;
    logic        interrupt_clear = 1'b0;
    logic [31:0] mem_data_out;
    logic        mem_ready;
    logic        tx;
    logic        interrupt;

    int compared = 0;
    int mismatched = 0;

    uart_tx_port #(.CLK_DIVIDER(4), .FIFO_BITS(3)) dut (
        .clk(clk), .nreset(nreset), .sel(sel), .mem_address(mem_address),
        .mem_valid(mem_valid), .mem_nwr(mem_nwr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_ready(mem_ready), .tx(tx),
        .interrupt(interrupt), .interrupt_clear(interrupt_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic addr, input logic [31:0] data);
        sel = 1'b1; mem_valid = 1'b1; mem_nwr = 1'b0; mem_address = addr; mem_data_in = data;
        tick();
        check("wr_ready", 32'(mem_ready), 32'd1);
        sel = 1'b0; mem_valid = 1'b0; mem_nwr = 1'b1;
        tick();
    endtask

    task automatic bus_read(input logic addr, output logic [31:0] data);
        sel = 1'b1; mem_valid = 1'b1; mem_nwr = 1'b1; mem_address = addr;
        tick();
        data = mem_data_out;
        sel = 1'b0; mem_valid = 1'b0;
        tick();
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    initial begin
        logic [31:0] rd;
        int          highs;

        // Reset and idle
        tick(3);
        check("rst_data_out", mem_data_out, 32'h0);
        check("rst_tx", 32'(tx), 32'd1);
        nreset = 1'b1;
        tick(10);
        check("idle_tx", 32'(tx), 32'd1);
        check("idle_irq", 32'(interrupt), 32'd0);
        check("idle_ready", 32'(mem_ready), 32'd0);
        bus_read(1'b1, rd);
        check("status_reset", rd, 32'h0000_0002);

        // Single frame 0xA5
        sel = 1'b1; mem_valid = 1'b1; mem_nwr = 1'b0; mem_address = 1'b0; mem_data_in = 32'hA5;
        tick();
        check("a5_ready", 32'(mem_ready), 32'd1);
        check("a5_tx_before", 32'(tx), 32'd1);
        sel = 1'b0; mem_valid = 1'b0; mem_nwr = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            check($sformatf("a5_bit%0d", k), 32'(tx), 32'(frame_bit(8'hA5, k)));
            tick(4);
        end
        check("a5_after_tx", 32'(tx), 32'd1);
        bus_read(1'b1, rd);
        check("a5_status_idle", rd, 32'h0000_0002);

        // Back-to-back frames 0x01, 0x80: every cycle checked, no gap allowed
        bus_write(1'b0, 32'h01);
        bus_write(1'b0, 32'h80);
        for (int c = 2; c < 80; c++) begin
            check($sformatf("b2b_cycle%0d", c), 32'(tx),
                  32'(frame_bit((c < 40) ? 8'h01 : 8'h80, (c % 40) / 4)));
            tick();
        end
        check("b2b_end_tx", 32'(tx), 32'd1);
        bus_read(1'b1, rd);
        check("b2b_status", rd, 32'h0000_0002);

        // Overflow: one byte popped, eight queued, tenth dropped
        for (int i = 0; i < 10; i++)
            bus_write(1'b0, 32'(i + 16));
        bus_read(1'b1, rd);
        check("ovf_status1", rd, 32'h0000_080D);
        bus_read(1'b1, rd);
        check("ovf_status2", rd, 32'h0000_0805);
        tick(360);
        bus_read(1'b1, rd);
        check("ovf_drained", rd, 32'h0000_0002);

        // Interrupt enable, then acknowledge
        sel = 1'b1; mem_valid = 1'b1; mem_nwr = 1'b0; mem_address = 1'b1; mem_data_in = 32'h1;
        tick();
        check("irq_not_yet", 32'(interrupt), 32'd0);
        sel = 1'b0; mem_valid = 1'b0; mem_nwr = 1'b1;
        tick();
        check("irq_set", 32'(interrupt), 32'd1);
        tick(2);
        check("irq_held", 32'(interrupt), 32'd1);
        interrupt_clear = 1'b1;
        tick();
        interrupt_clear = 1'b0;
        tick();
        check("irq_cleared", 32'(interrupt), 32'd0);
        bus_write(1'b0, 32'h3C);
        tick(50);
        check("irq_after_frame", 32'(interrupt), 32'd0);

        // Clear beats a simultaneous STATUS write
        sel = 1'b1; mem_valid = 1'b1; mem_nwr = 1'b0; mem_address = 1'b1; mem_data_in = 32'h1;
        interrupt_clear = 1'b1;
        tick();
        interrupt_clear = 1'b0;
        sel = 1'b0; mem_valid = 1'b0; mem_nwr = 1'b1;
        tick(3);
        check("irq_clear_wins", 32'(interrupt), 32'd0);

        // Reset during data bit 3 with a second byte queued
        bus_write(1'b0, 32'h00);
        bus_write(1'b0, 32'h00);
        tick(15);
        check("mid_frame_tx_low", 32'(tx), 32'd0);
        nreset = 1'b0;
        #1;
        check("async_rst_tx", 32'(tx), 32'd1);
        check("async_rst_ready", 32'(mem_ready), 32'd0);
        tick(2);
        nreset = 1'b1;
        highs = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (tx === 1'b1) highs++;
        end
        check("no_residual_frame", 32'(highs), 32'd50);
        bus_read(1'b1, rd);
        check("post_rst_status", rd, 32'h0000_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
